// File: rtl/float_accum_seq.sv
// -----------------------------------------------------------------------------
// float_accum_seq
//
// Sequential accumulator for batches of IEEE-754 single-precision operands.
// Operands arrive through a small input FIFO; the block chains them through an
// external floating-point adder one pair at a time, strictly in arrival order
// (running sum is always operand 1, the newest operand is operand 2), and
// presents the batch total when the operand tagged InLast has been folded in.
// No arithmetic is done here: all values move bit-exact between FIFO,
// accumulator, adder ports and the Sum output.
//
// Parameters
//   DEPTH    input FIFO entries, power of two, >= 2
//   TIMEOUT  cycles (counted from the issue cycle) to wait for an adder result
//
// Ports
//   Clock           rising-edge clock
//   Reset           synchronous, active-high reset
//   InData/InLast   operand and end-of-batch marker, valid with InValid
//   InValid/InReady upstream handshake; transfer when both are high
//   AddOp1/AddOp2   operands to the adder, stable from issue until result
//   AddInputValid   one-cycle issue strobe to the adder
//   AddResult/AddResultValid  adder response
//   Sum/SumValid    batch total with a one-cycle strobe; Sum holds between
//   Busy            FSM active, or FIFO / accumulator holding data
//   Error           one-cycle adder-timeout strobe
//
// Optional feature
//   FLOAT_ACCUM_TIMEOUT_EN  when defined, a watchdog bounds the wait for the
//   adder; on expiry Error pulses, the partial sum is dropped and the rest of
//   that batch (up to and including its InLast entry) is discarded. When
//   undefined the FSM waits for the adder indefinitely and Error is tied low.
// -----------------------------------------------------------------------------
module float_accum_seq #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] InData,
    input  logic        InLast,
    input  logic        InValid,
    output logic        InReady,
    output logic [31:0] AddOp1,
    output logic [31:0] AddOp2,
    output logic        AddInputValid,
    input  logic [31:0] AddResult,
    input  logic        AddResultValid,
    output logic [31:0] Sum,
    output logic        SumValid,
    output logic        Busy,
    output logic        Error
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Reject configurations the pointer arithmetic and watchdog cannot support.
    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT < 2)) begin : g_bad_params
            $error("float_accum_seq: DEPTH must be a power of two >= 2 and TIMEOUT >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input FIFO: entries are {last, data}
    // ------------------------------------------------------------------
    logic [32:0]   fifo_mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          in_ready_q, in_ready_d;
    logic          push_s;
    logic          pop_s;
    logic          fifo_empty_s;
    logic [32:0]   head_s;
    logic [31:0]   head_data_s;
    logic          head_last_s;

    // ------------------------------------------------------------------
    // Control and datapath registers
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [31:0]   acc_q, acc_d;
    logic          acc_valid_q, acc_valid_d;
    logic          pend_last_q, pend_last_d;
    logic [31:0]   op1_q, op1_d;
    logic [31:0]   op2_q, op2_d;
    logic          add_valid_q, add_valid_d;
    logic [31:0]   sum_q, sum_d;
    logic          sum_valid_q, sum_valid_d;
    logic          busy_q, busy_d;

`ifdef FLOAT_ACCUM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          drop_q, drop_d;
    logic          error_q, error_d;
`endif

    // InReady is registered, so a push is only ever accepted into a free slot.
    assign push_s       = InValid && in_ready_q;
    assign fifo_empty_s = (count_q == {CW{1'b0}});
    assign head_s       = fifo_mem_q[rd_ptr_q];
    assign head_data_s  = head_s[31:0];
    assign head_last_s  = head_s[32];

    // FIFO pointer, occupancy and ready bookkeeping.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        in_ready_d = in_ready_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        in_ready_d = (count_d != FULL_COUNT);
    end

    // Accumulation FSM: next state, pops and datapath register updates.
    always_comb begin
        state_d     = state_q;
        pop_s       = 1'b0;
        acc_d       = acc_q;
        acc_valid_d = acc_valid_q;
        pend_last_d = pend_last_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        add_valid_d = 1'b0;
        sum_d       = sum_q;
        sum_valid_d = 1'b0;
`ifdef FLOAT_ACCUM_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        drop_d      = drop_q;
        error_d     = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (fifo_empty_s) begin
                    state_d = ST_IDLE;
                end
`ifdef FLOAT_ACCUM_TIMEOUT_EN
                // Flushing the remainder of a batch whose add timed out.
                else if (drop_q) begin
                    pop_s = 1'b1;
                    if (head_last_s) begin
                        drop_d = 1'b0;
                    end else begin
                        drop_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
`endif
                // First operand of a batch seeds the accumulator directly.
                else if (!acc_valid_q) begin
                    pop_s       = 1'b1;
                    acc_d       = head_data_s;
                    acc_valid_d = 1'b1;
                    if (head_last_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    // Running sum is operand 1, newest operand is operand 2.
                    pop_s       = 1'b1;
                    op1_d       = acc_q;
                    op2_d       = head_data_s;
                    pend_last_d = head_last_s;
                    add_valid_d = 1'b1;
                    state_d     = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                // Any AddResultValid seen here belongs to nothing we issued.
                state_d = ST_WAIT;
`ifdef FLOAT_ACCUM_TIMEOUT_EN
                tmo_cnt_d = TW'(1);
`endif
            end

            ST_WAIT: begin
                if (AddResultValid) begin
                    acc_d = AddResult;
`ifdef FLOAT_ACCUM_TIMEOUT_EN
                    tmo_cnt_d = {TW{1'b0}};
`endif
                    if (pend_last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
`ifdef FLOAT_ACCUM_TIMEOUT_EN
                // Counter equals cycles since issue; expiring here makes the
                // registered Error land exactly TIMEOUT cycles after issue.
                else if (tmo_cnt_q == TMO_LAST) begin
                    error_d     = 1'b1;
                    acc_valid_d = 1'b0;
                    drop_d      = ~pend_last_q;
                    tmo_cnt_d   = {TW{1'b0}};
                    state_d     = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                    state_d   = ST_WAIT;
                end
`else
                else begin
                    state_d = ST_WAIT;
                end
`endif
            end

            ST_DONE: begin
                sum_d       = acc_q;
                sum_valid_d = 1'b1;
                acc_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end

            default: begin
                state_d     = ST_IDLE;
                acc_valid_d = 1'b0;
            end
        endcase
    end

    // Busy reflects the state and storage the block will hold next cycle.
    always_comb begin
        busy_d = (state_d != ST_IDLE) || (count_d != {CW{1'b0}}) || acc_valid_d;
    end

    // FIFO storage; contents are don't-care while pointers mark them empty.
    always_ff @(posedge Clock) begin
        if (push_s) begin
            fifo_mem_q[wr_ptr_q] <= {InLast, InData};
        end
    end

    // Control/datapath state registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            count_q     <= {CW{1'b0}};
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
            acc_q       <= 32'h0000_0000;
            acc_valid_q <= 1'b0;
            pend_last_q <= 1'b0;
            op1_q       <= 32'h0000_0000;
            op2_q       <= 32'h0000_0000;
            add_valid_q <= 1'b0;
            sum_q       <= 32'h0000_0000;
            sum_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef FLOAT_ACCUM_TIMEOUT_EN
            tmo_cnt_q   <= {TW{1'b0}};
            drop_q      <= 1'b0;
            error_q     <= 1'b0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            state_q     <= state_d;
            acc_q       <= acc_d;
            acc_valid_q <= acc_valid_d;
            pend_last_q <= pend_last_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            add_valid_q <= add_valid_d;
            sum_q       <= sum_d;
            sum_valid_q <= sum_valid_d;
            busy_q      <= busy_d;
`ifdef FLOAT_ACCUM_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            drop_q      <= drop_d;
            error_q     <= error_d;
`endif
        end
    end

    assign InReady       = in_ready_q;
    assign AddOp1        = op1_q;
    assign AddOp2        = op2_q;
    assign AddInputValid = add_valid_q;
    assign Sum           = sum_q;
    assign SumValid      = sum_valid_q;
    assign Busy          = busy_q;
`ifdef FLOAT_ACCUM_TIMEOUT_EN
    assign Error         = error_q;
`else
    assign Error         = 1'b0;
`endif

endmodule

// File: tb/tb_float_accum_seq.sv
// Directed testbench for float_accum_seq. A behavioural adder with adjustable
// latency answers issues (integer-valued positive floats only); expected sums
// are hand-computed constants.
module tb_float_accum_seq;

    localparam int TB_TIMEOUT = 16;

    logic        Clock;
    logic        Reset;
    logic [31:0] InData;
    logic        InLast;
    logic        InValid;
    logic        InReady;
    logic [31:0] AddOp1;
    logic [31:0] AddOp2;
    logic        AddInputValid;
    logic [31:0] AddResult;
    logic        AddResultValid;
    logic [31:0] Sum;
    logic        SumValid;
    logic        Busy;
    logic        Error;

    int errors = 0;
    int checks = 0;

    // Adder model controls (written only by the stimulus block)
    int add_lat  = 3;
    bit rv_hold  = 1'b0;
    bit add_mute = 1'b0;

    // Adder model pipeline (written only by the adder process)
    logic        pipe_v [0:31] = '{default: 1'b0};
    logic [31:0] pipe_d [0:31] = '{default: 32'h0};

    // Event counters (written only by the monitor)
    int          issue_cnt = 0;
    int          sum_cnt   = 0;
    int          err_cnt   = 0;
    logic [31:0] op1_log [0:63];
    logic [31:0] op2_log [0:63];

    float_accum_seq #(.DEPTH(4), .TIMEOUT(TB_TIMEOUT)) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .InData         (InData),
        .InLast         (InLast),
        .InValid        (InValid),
        .InReady        (InReady),
        .AddOp1         (AddOp1),
        .AddOp2         (AddOp2),
        .AddInputValid  (AddInputValid),
        .AddResult      (AddResult),
        .AddResultValid (AddResultValid),
        .Sum            (Sum),
        .SumValid       (SumValid),
        .Busy           (Busy),
        .Error          (Error)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Small positive integer float -> int
    function automatic int f2i(input logic [31:0] f);
        int e;
        int m;
        if (f[30:23] == 8'd0) return 0;
        e = int'(f[30:23]) - 127;
        m = int'({1'b1, f[22:0]});
        if (e < 0) return 0;
        if (e > 23) return m << (e - 23);
        return m >> (23 - e);
    endfunction

    // Small positive int -> float
    function automatic logic [31:0] i2f(input int v);
        int          p;
        logic [31:0] t;
        logic [31:0] r;
        if (v <= 0) return 32'h0;
        t = v;
        p = 0;
        for (int i = 0; i < 31; i++) if (t[i]) p = i;
        t = t << (23 - p);
        r = {1'b0, 8'(127 + p), t[22:0]};
        return r;
    endfunction

    // Adder model: result appears add_lat cycles after the issue cycle
    always @(negedge Clock) begin
        for (int i = 31; i > 0; i--) begin
            pipe_v[i] = pipe_v[i-1];
            pipe_d[i] = pipe_d[i-1];
        end
        pipe_v[0] = (AddInputValid === 1'b1) && !add_mute;
        pipe_d[0] = i2f(f2i(AddOp1) + f2i(AddOp2));
        AddResultValid = rv_hold || pipe_v[add_lat];
        AddResult      = pipe_d[add_lat];
    end

    // Monitor: counts issues, sums and error pulses
    always @(negedge Clock) begin
        if (AddInputValid === 1'b1) begin
            op1_log[issue_cnt % 64] = AddOp1;
            op2_log[issue_cnt % 64] = AddOp2;
            issue_cnt++;
        end
        if (SumValid === 1'b1) sum_cnt++;
        if (Error === 1'b1) err_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic push(input logic [31:0] d, input logic l);
        int w;
        w = 0;
        InData  = d;
        InLast  = l;
        InValid = 1'b1;
        while (InReady !== 1'b1 && w < 200) begin
            step();
            w++;
        end
        chk("push_ready", {31'b0, InReady}, 32'd1);
        step();
        InValid = 1'b0;
        InLast  = 1'b0;
    endtask

    task automatic wait_sum(input string tag, input logic [31:0] exp);
        int w;
        w = 0;
        while (SumValid !== 1'b1 && w < 600) begin
            step();
            w++;
        end
        chk("sum_valid_seen", {31'b0, SumValid}, 32'd1);
        chk(tag, Sum, exp);
    endtask

    task automatic wait_issue();
        int w;
        w = 0;
        while (AddInputValid !== 1'b1 && w < 50) begin
            step();
            w++;
        end
        chk("issue_seen", {31'b0, AddInputValid}, 32'd1);
    endtask

    int base_i;
    int base_s;
    int base_e;
    bit early;

    initial begin
        Reset   = 1'b1;
        InValid = 1'b0;
        InData  = 32'h0;
        InLast  = 1'b0;
        idle(3);
        Reset = 1'b0;

        // Reset state
        chk("rst_inready", {31'b0, InReady}, 32'd1);
        chk("rst_op1", AddOp1, 32'h0);
        chk("rst_op2", AddOp2, 32'h0);
        chk("rst_addvalid", {31'b0, AddInputValid}, 32'd0);
        chk("rst_sum", Sum, 32'h0);
        chk("rst_sumvalid", {31'b0, SumValid}, 32'd0);
        chk("rst_busy", {31'b0, Busy}, 32'd0);
        chk("rst_error", {31'b0, Error}, 32'd0);

        // 1.0 + 2.0 + 3.0 = 6.0, adder latency 3
        add_lat = 3;
        base_i = issue_cnt;
        base_s = sum_cnt;
        push(32'h3F800000, 1'b0);
        push(32'h40000000, 1'b0);
        push(32'h40400000, 1'b1);
        wait_sum("sum_123", 32'h40C00000);
        idle(2);
        chk("b1_issues", issue_cnt - base_i, 32'd2);
        chk("b1_sums", sum_cnt - base_s, 32'd1);
        chk("b1_op1_first", op1_log[base_i % 64], 32'h3F800000);
        chk("b1_op2_first", op2_log[base_i % 64], 32'h40000000);
        chk("b1_op1_second", op1_log[(base_i + 1) % 64], 32'h40400000);
        chk("b1_op2_second", op2_log[(base_i + 1) % 64], 32'h40400000);
        chk("b1_sum_hold", Sum, 32'h40C00000);
        chk("b1_sumvalid_low", {31'b0, SumValid}, 32'd0);

        // Single-operand batch: no adder issue, strobe two edges after push
        idle(5);
        base_i = issue_cnt;
        push(32'h40400000, 1'b1);
        step();
        chk("single_early", {31'b0, SumValid}, 32'd0);
        step();
        chk("single_valid", {31'b0, SumValid}, 32'd1);
        chk("single_sum", Sum, 32'h40400000);
        step();
        chk("single_pulse", {31'b0, SumValid}, 32'd0);
        chk("single_no_issue", issue_cnt - base_i, 32'd0);

        // Six back-to-back operands into a 4-deep FIFO while the adder is slow
        idle(40);
        add_lat = 20;
        base_i = issue_cnt;
        push(32'h3F800000, 1'b0);
        push(32'h40000000, 1'b0);
        push(32'h40400000, 1'b0);
        push(32'h40800000, 1'b0);
        push(32'h40A00000, 1'b0);
        push(32'h40C00000, 1'b1);
        chk("full_inready", {31'b0, InReady}, 32'd0);
        chk("full_busy", {31'b0, Busy}, 32'd1);
        wait_sum("sum_1to6", 32'h41A80000);
        chk("b3_issues", issue_cnt - base_i, 32'd5);
        step();
        chk("b3_inready_back", {31'b0, InReady}, 32'd1);

        // Reset while waiting on the adder; late result must be ignored
        idle(40);
        add_lat = 10;
        push(32'h3F800000, 1'b0);
        push(32'h40000000, 1'b1);
        wait_issue();
        idle(3);
        chk("mid_busy", {31'b0, Busy}, 32'd1);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        base_s = sum_cnt;
        chk("mid_rst_busy", {31'b0, Busy}, 32'd0);
        chk("mid_rst_sum", Sum, 32'h0);
        chk("mid_rst_op1", AddOp1, 32'h0);
        idle(20);
        chk("mid_no_sum", sum_cnt - base_s, 32'd0);
        chk("mid_idle_busy", {31'b0, Busy}, 32'd0);
        push(32'h40000000, 1'b0);
        push(32'h40000000, 1'b1);
        wait_sum("sum_after_rst", 32'h40800000);

        // AddResultValid held high: capture only in WAIT, one per issue
        idle(40);
        add_lat = 1;
        rv_hold = 1'b1;
        base_i = issue_cnt;
        base_s = sum_cnt;
        push(32'h3F800000, 1'b0);
        push(32'h40000000, 1'b0);
        push(32'h40400000, 1'b1);
        wait_sum("sum_hold_rv", 32'h40C00000);
        idle(3);
        chk("hold_issues", issue_cnt - base_i, 32'd2);
        chk("hold_sums", sum_cnt - base_s, 32'd1);
        rv_hold = 1'b0;

`ifdef FLOAT_ACCUM_TIMEOUT_EN
        // Adder never answers: Error exactly TIMEOUT cycles after issue
        idle(40);
        add_mute = 1'b1;
        base_s = sum_cnt;
        base_e = err_cnt;
        push(32'h3F800000, 1'b0);
        push(32'h40000000, 1'b0);
        push(32'h40A00000, 1'b1);
        wait_issue();
        early = 1'b0;
        for (int j = 1; j <= TB_TIMEOUT; j++) begin
            step();
            if (j < TB_TIMEOUT && Error === 1'b1) early = 1'b1;
        end
        chk("tmo_pulse", {31'b0, Error}, 32'd1);
        chk("tmo_early", {31'b0, early}, 32'd0);
        step();
        chk("tmo_single", {31'b0, Error}, 32'd0);
        idle(4);
        chk("tmo_idle_busy", {31'b0, Busy}, 32'd0);
        chk("tmo_no_sum", sum_cnt - base_s, 32'd0);
        chk("tmo_err_count", err_cnt - base_e, 32'd1);
        add_mute = 1'b0;
        push(32'h40000000, 1'b0);
        push(32'h40000000, 1'b1);
        wait_sum("sum_after_tmo", 32'h40800000);
`else
        chk("no_error_pulses", err_cnt, 32'd0);
        chk("error_low", {31'b0, Error}, 32'd0);
`endif

        idle(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
